// File: rtl/flit_packetizer.sv
// Wormhole flit packetizer: turns a packet request plus payload words into
// HEAD/BODY/TAIL flits, gated by a credit count toward the downstream buffer.
module flit_packetizer #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 4,
   parameter int MAX_LEN   = 8,
   parameter int BUF_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pkt_valid,
   output logic                       pkt_ready,
   input  logic [ADDR_W-1:0]          pkt_dest,
   input  logic [3:0]                 pkt_len,
   input  logic                       data_valid,
   output logic                       data_ready,
   input  logic [DATA_W-1:0]          data_in,
   output logic                       flit_valid,
   output logic [2+ADDR_W+DATA_W-1:0] flit_out,
   input  logic                       credit_in,
   output logic                       credit_err,
   output logic [15:0]                pkt_count
);

   localparam int FLIT_W = 2 + ADDR_W + DATA_W;
   localparam int CRD_W  = $clog2(BUF_DEPTH + 1);

   localparam logic [1:0] T_BODY = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_HT   = 2'b11;

   localparam logic [3:0]       MAX_LEN_C = 4'(MAX_LEN);
   localparam logic [CRD_W-1:0] CRD_FULL  = CRD_W'(BUF_DEPTH);
   localparam logic [CRD_W-1:0] CRD_ONE   = CRD_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEAD,
      S_BODY
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   dest_q, dest_d;
   logic [3:0]          len_q, len_d;
   logic [3:0]          rem_q, rem_d;
   logic [CRD_W-1:0]    credit_q, credit_d;
   logic                credit_err_q, credit_err_d;
   logic                flit_valid_q, flit_valid_d;
   logic [FLIT_W-1:0]   flit_out_q, flit_out_d;
   logic [15:0]         pkt_count_q, pkt_count_d;

   logic                has_credit;
   logic                send;
   logic                last;
   logic [3:0]          len_clamp;

   assign has_credit = (credit_q != '0);
   assign len_clamp  = (pkt_len > MAX_LEN_C) ? MAX_LEN_C : pkt_len;

   assign pkt_ready  = (state_q == S_IDLE);
   assign data_ready = (state_q == S_BODY) && has_credit;

   always_comb begin
      state_d      = state_q;
      dest_d       = dest_q;
      len_d        = len_q;
      rem_d        = rem_q;
      credit_d     = credit_q;
      credit_err_d = credit_err_q;
      flit_out_d   = flit_out_q;
      pkt_count_d  = pkt_count_q;
      send         = 1'b0;
      last         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (pkt_valid) begin
               dest_d  = pkt_dest;
               len_d   = len_clamp;
               rem_d   = len_clamp;
               state_d = S_HEAD;
            end
         end
         S_HEAD: begin
            if (has_credit) begin
               send       = 1'b1;
               last       = (len_q == 4'd0);
               flit_out_d = {last ? T_HT : T_HEAD, dest_q,
                             DATA_W'(len_q)};
               state_d    = last ? S_IDLE : S_BODY;
            end
         end
         S_BODY: begin
            if (data_valid && has_credit) begin
               send       = 1'b1;
               last       = (rem_q == 4'd1);
               flit_out_d = {last ? T_TAIL : T_BODY, dest_q, data_in};
               rem_d      = rem_q - 4'd1;
               if (last) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      flit_valid_d = send;

      // A send and a returned credit in the same cycle cancel out.
      if (send && !credit_in) begin
         credit_d = credit_q - CRD_ONE;
      end else if (!send && credit_in) begin
         if (credit_q == CRD_FULL) credit_err_d = 1'b1;
         else                      credit_d     = credit_q + CRD_ONE;
      end

      if (send && last) pkt_count_d = pkt_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dest_q       <= '0;
         len_q        <= '0;
         rem_q        <= '0;
         credit_q     <= CRD_FULL;
         credit_err_q <= 1'b0;
         flit_valid_q <= 1'b0;
         flit_out_q   <= '0;
         pkt_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         dest_q       <= dest_d;
         len_q        <= len_d;
         rem_q        <= rem_d;
         credit_q     <= credit_d;
         credit_err_q <= credit_err_d;
         flit_valid_q <= flit_valid_d;
         flit_out_q   <= flit_out_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign flit_valid = flit_valid_q;
   assign flit_out   = flit_out_q;
   assign credit_err = credit_err_q;
   assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_flit_packetizer.sv
// Scoreboard bench for flit_packetizer: directed packets push expected
// flits, a negedge monitor pops and compares every emitted flit.
module tb_flit_packetizer;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int FW = 2 + AW + DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pkt_valid = 1'b0;
   logic          pkt_ready;
   logic [AW-1:0] pkt_dest = '0;
   logic [3:0]    pkt_len = '0;
   logic          data_valid = 1'b0;
   logic          data_ready;
   logic [DW-1:0] data_in = '0;
   logic          flit_valid;
   logic [FW-1:0] flit_out;
   logic          credit_in = 1'b0;
   logic          credit_err;
   logic [15:0]   pkt_count;

   always #5 clk = ~clk;

   flit_packetizer #(
      .DATA_W(DW), .ADDR_W(AW), .MAX_LEN(8), .BUF_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_dest(pkt_dest), .pkt_len(pkt_len),
      .data_valid(data_valid), .data_ready(data_ready),
      .data_in(data_in),
      .flit_valid(flit_valid), .flit_out(flit_out),
      .credit_in(credit_in), .credit_err(credit_err),
      .pkt_count(pkt_count)
   );

   logic [FW-1:0] exp_q[$];
   logic [FW-1:0] mon_exp;
   int checks = 0;
   int errors = 0;
   int nflits = 0;

   function automatic logic [FW-1:0] mk(input logic [1:0] t,
                                        input logic [AW-1:0] d,
                                        input logic [DW-1:0] p);
      return {t, d, p};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   always @(negedge clk) begin
      if (rst_n && flit_valid) begin
         nflits++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_flit actual=%0h required=none",
                     flit_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (flit_out !== mon_exp) begin
               errors++;
               $display("FAIL flit actual=%0h required=%0h",
                        flit_out, mon_exp);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n      = 1'b0;
      pkt_valid  = 1'b0;
      data_valid = 1'b0;
      credit_in  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic req(input logic [AW-1:0] d, input logic [3:0] l);
      int n;
      logic [3:0] lc;
      n  = 0;
      lc = (l > 4'd8) ? 4'd8 : l;
      exp_q.push_back(mk((lc == 4'd0) ? 2'b11 : 2'b01, d, DW'(lc)));
      pkt_dest  = d;
      pkt_len   = l;
      pkt_valid = 1'b1;
      while (!pkt_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) timeout("pkt_handshake");
      @(posedge clk);
      #1;
      pkt_valid = 1'b0;
   endtask

   task automatic feed(input logic [AW-1:0] d, input logic [DW-1:0] w,
                       input bit last, output int waits);
      waits      = 0;
      data_valid = 1'b1;
      data_in    = w;
      while (!data_ready && waits < 50) begin
         @(posedge clk);
         #1;
         waits++;
      end
      if (waits >= 50) begin
         timeout("data_handshake");
      end else begin
         exp_q.push_back(mk(last ? 2'b10 : 2'b00, d, w));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int snap;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flit_valid", 64'(flit_valid), 64'd0);
      chk("rst_flit_out", 64'(flit_out), 64'd0);
      chk("rst_data_ready", 64'(data_ready), 64'd0);
      chk("rst_credit_err", 64'(credit_err), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_pkt_ready", 64'(pkt_ready), 64'd1);

      // single head_tail flit
      req(4'h5, 4'd0);
      @(posedge clk);
      #1;
      chk("ht_valid", 64'(flit_valid), 64'd1);
      chk("ht_flit", 64'(flit_out), 64'(mk(2'b11, 4'h5, 32'd0)));
      chk("ht_pkt_count", 64'(pkt_count), 64'd1);
      @(posedge clk);
      #1;
      chk("ht_valid_low", 64'(flit_valid), 64'd0);
      chk("ht_hold", 64'(flit_out), 64'(mk(2'b11, 4'h5, 32'd0)));

      // len=3 back-to-back, credit runs out
      do_reset();
      req(4'h3, 4'd3);
      feed(4'h3, 32'h0000_000A, 1'b0, w);
      chk("b2b_wait_a", 64'(w), 64'd1);
      feed(4'h3, 32'h0000_000B, 1'b0, w);
      chk("b2b_wait_b", 64'(w), 64'd0);
      feed(4'h3, 32'h0000_000C, 1'b1, w);
      chk("b2b_wait_c", 64'(w), 64'd0);
      data_valid = 1'b0;
      drain();
      chk("b2b_pkt_count", 64'(pkt_count), 64'd1);
      req(4'h1, 4'd0);
      snap = nflits;
      repeat (4) @(posedge clk);
      #1;
      chk("zero_credit_stall", 64'(nflits - snap), 64'd0);
      chk("zero_credit_busy", 64'(pkt_ready), 64'd0);
      credit_in = 1'b1;
      @(posedge clk);
      #1;
      credit_in = 1'b0;
      drain();
      chk("resume_pkt_count", 64'(pkt_count), 64'd2);
      chk("resume_no_err", 64'(credit_err), 64'd0);

      // len=6 with BUF_DEPTH=4
      do_reset();
      snap = nflits;
      req(4'h7, 4'd6);
      feed(4'h7, 32'hD000_0000, 1'b0, w);
      feed(4'h7, 32'hD000_0001, 1'b0, w);
      feed(4'h7, 32'hD000_0002, 1'b0, w);
      data_valid = 1'b1;
      data_in    = 32'hD000_0003;
      drain();
      chk("stall_flits", 64'(nflits - snap), 64'd4);
      chk("stall_ready0", 64'(data_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("stall_ready1", 64'(data_ready), 64'd0);
      fork
         begin
            repeat (3) begin
               credit_in = 1'b1;
               @(posedge clk);
               #1;
            end
            credit_in = 1'b0;
         end
         begin
            int w2;
            feed(4'h7, 32'hD000_0003, 1'b0, w2);
            feed(4'h7, 32'hD000_0004, 1'b0, w2);
            feed(4'h7, 32'hD000_0005, 1'b1, w2);
            data_valid = 1'b0;
         end
      join
      drain();
      chk("len6_flits", 64'(nflits - snap), 64'd7);
      chk("len6_pkt_count", 64'(pkt_count), 64'd1);

      // credit overflow while idle
      do_reset();
      chk("ovf_err_before", 64'(credit_err), 64'd0);
      credit_in = 1'b1;
      @(posedge clk);
      #1;
      credit_in = 1'b0;
      chk("ovf_err_set", 64'(credit_err), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("ovf_err_sticky", 64'(credit_err), 64'd1);
      req(4'h2, 4'd4);
      feed(4'h2, 32'h1111_0000, 1'b0, w);
      feed(4'h2, 32'h1111_0001, 1'b0, w);
      feed(4'h2, 32'h1111_0002, 1'b0, w);
      drain();
      chk("ovf_saturated", 64'(data_ready), 64'd0);
      credit_in = 1'b1;
      @(posedge clk);
      #1;
      credit_in = 1'b0;
      feed(4'h2, 32'h1111_0003, 1'b1, w);
      data_valid = 1'b0;
      drain();
      chk("ovf_err_still", 64'(credit_err), 64'd1);
      do_reset();
      chk("ovf_err_cleared", 64'(credit_err), 64'd0);

      // reset mid-packet
      req(4'h8, 4'd0);
      drain();
      req(4'h9, 4'd4);
      feed(4'h9, 32'hCAFE_0000, 1'b0, w);
      data_valid = 1'b0;
      drain();
      chk("mid_pkt_count_pre", 64'(pkt_count), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 64'(flit_valid), 64'd0);
      chk("mid_rst_flit", 64'(flit_out), 64'd0);
      chk("mid_rst_dready", 64'(data_ready), 64'd0);
      chk("mid_rst_count", 64'(pkt_count), 64'd0);
      rst_n = 1'b1;
      chk("mid_rst_pready", 64'(pkt_ready), 64'd1);
      req(4'h2, 4'd1);
      feed(4'h2, 32'h0000_00EE, 1'b1, w);
      data_valid = 1'b0;
      drain();
      chk("mid_new_count", 64'(pkt_count), 64'd1);

      // send with simultaneous credit, clamped length
      do_reset();
      req(4'h6, 4'd2);
      feed(4'h6, 32'h6000_0000, 1'b0, w);
      feed(4'h6, 32'h6000_0001, 1'b1, w);
      data_valid = 1'b0;
      drain();
      req(4'hA, 4'd12);
      credit_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         feed(4'hA, 32'hA000_0000 + DW'(i), i == 7, w);
         if (i > 0) chk("clamp_no_stall", 64'(w), 64'd0);
      end
      credit_in  = 1'b0;
      data_valid = 1'b0;
      drain();
      chk("clamp_pkt_count", 64'(pkt_count), 64'd2);
      chk("clamp_pready", 64'(pkt_ready), 64'd1);
      req(4'hB, 4'd1);
      repeat (2) @(posedge clk);
      #1;
      drain();
      chk("credit_held_one", 64'(data_ready), 64'd0);
      chk("clamp_no_err", 64'(credit_err), 64'd0);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flit_packetizer.md
FLIT_PACKETIZER -- requirements
Module: flit_packetizer

Interface
REQ-001 Parameter DATA_W, default 32, payload bits per flit.
REQ-002 Parameter ADDR_W, default 4, destination router address width.
REQ-003 Parameter MAX_LEN, default 8, maximum payload words per packet.
REQ-004 Parameter BUF_DEPTH, default 4, downstream router input-buffer depth in flits; initial credit count.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 pkt_valid  input  1  packet request present.
REQ-008 pkt_ready  output  1  packetizer can accept a packet request.
REQ-009 pkt_dest  input  ADDR_W  destination address; sampled on pkt_valid&pkt_ready.
REQ-010 pkt_len  input  4  payload word count, 0..MAX_LEN; sampled with pkt_dest.
REQ-011 data_valid  input  1  payload word present.
REQ-012 data_ready  output  1  packetizer consumes the payload word this cycle.
REQ-013 data_in  input  DATA_W  payload word.
REQ-014 flit_valid  output  1  flit_out valid this cycle; one flit per asserted cycle.
REQ-015 flit_out  output  2+ADDR_W+DATA_W  {type[1:0], dest, payload}.
REQ-016 credit_in  input  1  one buffer slot freed downstream.
REQ-017 credit_err  output  1  sticky credit-overflow flag.
REQ-018 pkt_count  output  16  packets fully sent, wrapping.

Function
REQ-019 Flit type encoding SHALL be BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11.
REQ-020 States SHALL be IDLE, HEAD, BODY.
REQ-021 pkt_ready SHALL be 1 only in IDLE; an accepted request latches dest/len and moves to HEAD.
REQ-022 pkt_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-023 In HEAD with credit>0: emit head flit next cycle, payload = len zero-extended; type HEAD_TAIL and return to IDLE if len==0, else type HEAD and go to BODY.
REQ-024 In BODY, data_ready SHALL equal credit>0; each data_valid&data_ready emits one flit next cycle carrying data_in and latched dest.
REQ-025 The last payload word SHALL be typed TAIL, others BODY; after TAIL, state returns to IDLE.
REQ-026 flit_valid/flit_out SHALL be registered: one cycle after the send decision; flit_out held at last value when flit_valid=0.
REQ-027 No flit SHALL be emitted when credit count is 0; state holds until credit returns.
REQ-028 Credit counter range 0..BUF_DEPTH: -1 per emitted flit, +1 per credit_in, unchanged on simultaneous send and credit_in.
REQ-029 credit_in at BUF_DEPTH with no send SHALL saturate the counter and set credit_err until reset.
REQ-030 pkt_count SHALL increment on the cycle a TAIL or HEAD_TAIL flit is emitted, wrapping 16'hFFFF->0.
REQ-031 Minimum packet throughput with ample credit: len+1 flits in len+1 consecutive cycles, plus one IDLE cycle between packets.

Reset
REQ-032 With rst_n=0 at a clock edge: state=IDLE, credit=BUF_DEPTH, flit_valid=0, flit_out=0, data_ready=0, credit_err=0, pkt_count=0; pkt_ready=1 after reset released.
REQ-033 Reset mid-packet SHALL abandon the packet with no TAIL emitted; credit restored to BUF_DEPTH.

Verification
REQ-034 dest=4'h5, len=0, credit=4 -> one flit {11,5,0} one cycle after acceptance; pkt_count=1; credit=3.
REQ-035 dest=4'h3, len=3, data A,B,C back-to-back, no credit_in -> flits HEAD(len=3), BODY A, BODY B, TAIL C in 4 consecutive cycles; credit=0.
REQ-036 BUF_DEPTH=4, len=6, no credit_in -> 4 flits then data_ready=0 stall; one credit_in pulse per cycle -> remaining 3 flits, final TAIL.
REQ-037 Idle, credit=4, credit_in pulse -> credit stays 4, credit_err=1 and remains 1 until rst_n=0.
REQ-038 rst_n=0 after HEAD and 1 BODY of len=4 -> outputs at reset values next cycle; new packet len=1 gives HEAD, TAIL normally.
REQ-039 Send on same cycle as credit_in at credit=1 -> credit stays 1; pkt_len=12 -> clamped to 8 body flits.
